connect: RTL and testbench
==========================

# connect

Washing-machine cycle controller. Sequences fill, wash, drain, rinse and spin phases from a single start command, and sizes the wash phase from a 2-bit load setting. Pauses all actuators while the door is open. Top-level control block: drives the water valve, agitator, motor, motor speed and drain pump directly.

## Interface
- FILL_CYC, 4: cycles per fill phase.
- WASH_BASE, 4: wash cycles for load 0; actual wash = WASH_BASE + 2*load.
- RINSE_CYC, 4: rinse agitation cycles.
- DRAIN_CYC, 4: cycles per drain phase.
- SPIN_CYC, 6: final spin cycles.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- door  in  1  1 = door open.
- start  in  1  start request, level-sampled in IDLE.
- load  in  2  load size 0..3; 0 = empty drum.
- agitator  out  1  agitator drive.
- motor  out  1  drum motor enable.
- pump  out  1  drain pump.
- speed  out  1  motor speed: 0 = low (agitate), 1 = high (spin).
- water  out  1  inlet water valve.

## Operation
- States: IDLE, FILL, WASH, DRAIN1, RFILL, RINSE, DRAIN2, SPIN. After SPIN, return to IDLE.
- Leave IDLE when all of these hold at a rising edge: start=1, door=0, load!=0. Next state is FILL.
- In IDLE, start is ignored when door=1 or load=0. In every other state, start is ignored.
- load is captured into a register when leaving IDLE. Changes to load mid-cycle have no effect.
- Outputs are a Moore decode of the state, gated by door:
  - IDLE: all 0.
  - FILL, RFILL: water=1.
  - WASH, RINSE: agitator=1, motor=1, speed=0.
  - DRAIN1, DRAIN2: pump=1.
  - SPIN: motor=1, pump=1, speed=1.
  - All outputs not listed are 0.
- Pause: while door=1 in any state other than IDLE, all outputs are 0 and the state and phase counter hold. When door returns to 0, the controller resumes in the same state with the remaining count intact.
- Outputs are combinational from state and door. They must be glitch-free with respect to the state register; there is no other output logic.

## Timing
- Reset (async assert, sync release): state=IDLE, counter=0, captured load=0, all outputs 0.
- Start accepted at edge k: FILL is active from edge k, so water=1 immediately after edge k.
- Each phase lasts exactly its parameter count of non-paused cycles. A counter loads duration-1 on state entry, decrements on each unpaused edge, and the state advances when the counter is 0.
- Total unpaused run time = FILL + WASH + DRAIN + FILL + RINSE + DRAIN + SPIN. With defaults and load=1, that is 4+6+4+4+4+4+6 = 32 cycles.
- If door rises on the same edge as the terminal count, the pause wins: no transition, and the count is held.
- If rst asserts mid-cycle, the controller returns to IDLE immediately with outputs 0. No drain is performed.

## Configuration
- RINSE_EN defined: full sequence including RFILL, RINSE and DRAIN2.
- RINSE_EN undefined: DRAIN1 goes straight to SPIN, and the RFILL/RINSE/DRAIN2 states are absent. With load=1, total run time is 20 cycles.

## Structure
- Package connect_pkg holds:
  - the state enum;
  - default phase-duration constants;
  - the wash-duration function (WASH_BASE + 2*load).
- One sub-module, phase_timer: a loadable down-counter with a hold input (the pause) and a zero flag. Count width is derived from the largest duration.

## Test plan
- Reset: rst=1 for 10 cycles → all outputs 0, state IDLE; after release with start=0, the controller stays idle.
- Normal run, RINSE_EN, load=1, one-cycle start pulse → water for 4 cycles, agitator+motor for 6, pump for 4, water 4, agitator 4, pump 4, then motor+pump+speed for 6, then all 0 (32 cycles total).
- Door pulse of one cycle during WASH → all outputs 0 for that cycle; WASH then completes with total agitation still 6 cycles, and the run finishes 1 cycle later (33 cycles).
- Start rejected: load=0, or door=1, while start=1 → stays IDLE, all outputs 0.
- Load scaling: load=3 → WASH lasts 10 cycles; start pulses issued mid-run are ignored.
- Mid-run reset in SPIN → outputs 0 immediately; a later start begins again at FILL.

Source files
------------

// File: rtl/connect_pkg.sv
// Shared types, default phase durations and helpers for the washing-machine controller.
// Build option: define RINSE_EN to include the rinse sub-sequence (RFILL, RINSE, DRAIN2).
package connect_pkg;

   localparam int DEF_FILL_CYC  = 4;
   localparam int DEF_WASH_BASE = 4;
   localparam int DEF_RINSE_CYC = 4;
   localparam int DEF_DRAIN_CYC = 4;
   localparam int DEF_SPIN_CYC  = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_WASH,
      S_DRAIN1,
`ifdef RINSE_EN
      S_RFILL,
      S_RINSE,
      S_DRAIN2,
`endif
      S_SPIN
   } state_e;

   typedef struct packed {
      logic water;
      logic agitator;
      logic motor;
      logic speed;
      logic pump;
   } act_t;

   function automatic int wash_cyc(input int base, input logic [1:0] ld);
      return base + 2 * int'(ld);
   endfunction

   function automatic int max5(input int a, input int b, input int c, input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

endpackage

// File: rtl/connect_phase_timer.sv
// Loadable down-counter for phase durations; hold freezes the count, zero flags terminal count.
module phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_en,
   input  logic [W-1:0] load_val,
   input  logic         hold,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load_en)
         cnt_d = load_val;
      else if (!hold && cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/connect.sv
// Washing-machine cycle controller: fill, wash, drain, [rinse fill, rinse, drain,] spin.
// Build option: RINSE_EN enables the rinse sub-sequence; without it DRAIN1 goes straight to SPIN.
module connect
   import connect_pkg::*;
#(
   parameter int FILL_CYC  = DEF_FILL_CYC,
   parameter int WASH_BASE = DEF_WASH_BASE,
   parameter int RINSE_CYC = DEF_RINSE_CYC,
   parameter int DRAIN_CYC = DEF_DRAIN_CYC,
   parameter int SPIN_CYC  = DEF_SPIN_CYC
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       door,
   input  logic       start,
   input  logic [1:0] load,
   output logic       agitator,
   output logic       motor,
   output logic       pump,
   output logic       speed,
   output logic       water
);

   localparam int MAX_CYC = max5(FILL_CYC, wash_cyc(WASH_BASE, 2'd3), RINSE_CYC, DRAIN_CYC, SPIN_CYC);
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   state_e             state_q, state_d;
   logic   [1:0]       load_q, load_d;
   logic               tmr_load, tmr_zero;
   logic   [CNT_W-1:0] tmr_val;
   act_t               act;

   function automatic state_e next_phase(input state_e s);
      case (s)
         S_FILL:   return S_WASH;
         S_WASH:   return S_DRAIN1;
`ifdef RINSE_EN
         S_DRAIN1: return S_RFILL;
         S_RFILL:  return S_RINSE;
         S_RINSE:  return S_DRAIN2;
         S_DRAIN2: return S_SPIN;
`else
         S_DRAIN1: return S_SPIN;
`endif
         default:  return S_IDLE;
      endcase
   endfunction

   function automatic int phase_len(input state_e s, input logic [1:0] ld);
      case (s)
         S_FILL:   return FILL_CYC;
         S_WASH:   return wash_cyc(WASH_BASE, ld);
         S_DRAIN1: return DRAIN_CYC;
`ifdef RINSE_EN
         S_RFILL:  return FILL_CYC;
         S_RINSE:  return RINSE_CYC;
         S_DRAIN2: return DRAIN_CYC;
`endif
         S_SPIN:   return SPIN_CYC;
         default:  return 1;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
      end
   end

   // An open door blocks both the start in IDLE and any phase advance, even at terminal count.
   always_comb begin
      state_d  = state_q;
      load_d   = load_q;
      tmr_load = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !door && load != 2'd0) begin
               state_d  = S_FILL;
               load_d   = load;
               tmr_load = 1'b1;
            end
         end
         default: begin
            if (!door && tmr_zero) begin
               state_d  = next_phase(state_q);
               tmr_load = 1'b1;
            end
         end
      endcase
   end

   assign tmr_val = CNT_W'(phase_len(state_d, load_d) - 1);

   phase_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load_en  (tmr_load),
      .load_val (tmr_val),
      .hold     (door),
      .zero     (tmr_zero)
   );

   always_comb begin
      act = '0;
      case (state_q)
         S_FILL:   act.water = 1'b1;
         S_WASH:   begin act.agitator = 1'b1; act.motor = 1'b1; end
         S_DRAIN1: act.pump = 1'b1;
`ifdef RINSE_EN
         S_RFILL:  act.water = 1'b1;
         S_RINSE:  begin act.agitator = 1'b1; act.motor = 1'b1; end
         S_DRAIN2: act.pump = 1'b1;
`endif
         S_SPIN:   begin act.motor = 1'b1; act.pump = 1'b1; act.speed = 1'b1; end
         default:  act = '0;
      endcase
      if (door) act = '0;
   end

   assign water    = act.water;
   assign agitator = act.agitator;
   assign motor    = act.motor;
   assign speed    = act.speed;
   assign pump     = act.pump;

endmodule

// File: tb/tb_connect.sv
// Directed self-checking bench for connect; expected actuator patterns are built from phase durations.
module tb_connect;

   logic       clk = 1'b0;
   logic       rst, door, start;
   logic [1:0] load;
   logic       agitator, motor, pump, speed, water;
   logic [4:0] outs;

   int vectors     = 0;
   int miscompares = 0;

   // Actuator vectors ordered {water, agitator, motor, speed, pump}.
   localparam logic [4:0] O_IDLE  = 5'b00000;
   localparam logic [4:0] O_FILL  = 5'b10000;
   localparam logic [4:0] O_AGIT  = 5'b01100;
   localparam logic [4:0] O_DRAIN = 5'b00001;
   localparam logic [4:0] O_SPIN  = 5'b00111;

   logic [4:0] exp_q[$];

   connect dut (
      .clk      (clk),
      .rst      (rst),
      .door     (door),
      .start    (start),
      .load     (load),
      .agitator (agitator),
      .motor    (motor),
      .pump     (pump),
      .speed    (speed),
      .water    (water)
   );

   always #5 clk = ~clk;

   assign outs = {water, agitator, motor, speed, pump};

   task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %b, expected %b", tag, got, want);
      end
   endtask

   function automatic void push(input logic [4:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endfunction

   function automatic void build(input int ld);
      exp_q.delete();
      push(O_FILL, 4);
      push(O_AGIT, 4 + 2 * ld);
      push(O_DRAIN, 4);
`ifdef RINSE_EN
      push(O_FILL, 4);
      push(O_AGIT, 4);
      push(O_DRAIN, 4);
`endif
      push(O_SPIN, 6);
   endfunction

   // Full run: door held open during cycle door_c, start re-pulsed during cycle start_c,
   // and load optionally cleared right after the accepting edge.
   task automatic run(input int ld, input int door_c, input int start_c, input bit clear_load);
      int e, c;
      load  = 2'(ld);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (clear_load) load = 2'd0;
      build(ld);
      e = 0;
      c = 0;
      while (e < exp_q.size()) begin
         door  = (c == door_c);
         start = (c == start_c);
         @(negedge clk);
         check($sformatf("run_ld%0d_c%0d", ld, c), outs, door ? O_IDLE : exp_q[e]);
         if (!door) e++;
         @(posedge clk); #1;
         c++;
      end
      door  = 1'b0;
      start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check($sformatf("run_ld%0d_idle", ld), outs, O_IDLE);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int spin_at;
      rst   = 1'b1;
      door  = 1'b0;
      start = 1'b1;
      load  = 2'd1;
      repeat (10) begin
         @(negedge clk);
         check("reset_hold", outs, O_IDLE);
      end
      start = 1'b0;
      rst   = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_idle", outs, O_IDLE);
      end
      @(posedge clk); #1;

      run(1, -1, -1, 1'b0);
      run(1, 6, -1, 1'b0);
      run(2, 11, -1, 1'b0);

      load  = 2'd0;
      start = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reject_load0", outs, O_IDLE);
      end
      @(posedge clk); #1;
      load = 2'd1;
      door = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("reject_door", outs, O_IDLE);
      end
      @(posedge clk); #1;
      door  = 1'b0;
      start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("reject_still_idle", outs, O_IDLE);
      end
      @(posedge clk); #1;

      run(3, -1, 12, 1'b1);

`ifdef RINSE_EN
      spin_at = 4 + 6 + 4 + 12;
`else
      spin_at = 4 + 6 + 4;
`endif
      load  = 2'd1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (spin_at + 2) @(posedge clk);
      @(negedge clk);
      check("pre_reset_spin", outs, O_SPIN);
      #1 rst = 1'b1;
      #1 check("async_reset_outs", outs, O_IDLE);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("after_mid_reset_idle", outs, O_IDLE);
      @(posedge clk); #1;

      run(2, -1, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
